// File: rtl/aplic_cfg_arbiter_pkg.sv
// aplic_cfg_arbiter_pkg: shared types for the APLIC config-port arbiter.
package aplic_cfg_arbiter_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_rsp_t;
    localparam cfg_rsp_t RSP_ZERO = '0;
    localparam cfg_rsp_t RSP_TMO  = '{rdata: 32'h0, error: 1'b1, ready: 1'b1};
endpackage

// File: rtl/aplic_rr_pick.sv
// aplic_rr_pick: first valid requester at or after ptr, wrapping modulo n.
module aplic_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] index
);
    always_comb begin
        int j;
        j = 0;
        found = 1'b0;
        index = '0;
        // descending scan so the lowest rotated offset wins last
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (valid[j]) begin
                found = 1'b1;
                index = PW'(j);
            end
        end
    end
endmodule

// File: rtl/aplic_cfg_arbiter.sv
// aplic_cfg_arbiter: round-robin sharing of the APLIC config port with a
// per-transaction timeout; one transaction in flight at a time.
module aplic_cfg_arbiter
    import aplic_cfg_arbiter_pkg::*;
#(
    parameter int  NR_MASTERS = 2,
    parameter int  TIMEOUT    = 256,
    parameter type reg_req_t  = cfg_req_t,
    parameter type reg_rsp_t  = cfg_rsp_t
) (
    input  logic     i_clk,
    input  logic     ni_rst,
    input  reg_req_t i_req [NR_MASTERS],
    output reg_rsp_t o_resp [NR_MASTERS],
    output reg_req_t o_req,
    input  reg_rsp_t i_resp,
    output logic     o_busy,
    output logic     o_timeout
);
    localparam int PW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [PW-1:0]   gnt, rr_ptr, pick, nxt_ptr;
    logic [CW-1:0]   cnt;
    logic [NR_MASTERS-1:0] vld;
    logic            found, tmo;
    reg_req_t        cur;

    always_comb begin
        for (int i = 0; i < NR_MASTERS; i++) vld[i] = i_req[i].valid;
    end

    aplic_rr_pick #(.N(NR_MASTERS), .PW(PW)) u_pick (
        .valid (vld),
        .ptr   (rr_ptr),
        .found (found),
        .index (pick)
    );

    assign cur     = i_req[gnt];
    assign tmo     = (TIMEOUT != 0) && (cnt == LAST);
    assign nxt_ptr = (gnt == PW'(NR_MASTERS - 1)) ? '0 : gnt + 1'b1;
    assign o_busy  = (state == BUSY);

    always_comb begin
        o_req     = '0;
        o_timeout = 1'b0;
        for (int i = 0; i < NR_MASTERS; i++) o_resp[i] = RSP_ZERO;
        if (state == BUSY) begin
            o_req       = cur;
            o_resp[gnt] = i_resp;
            // a real response on the timeout cycle takes precedence
            if (cur.valid && tmo && !i_resp.ready) begin
                o_req.valid = 1'b0;
                o_resp[gnt] = RSP_TMO;
                o_timeout   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= BUSY;
                gnt   <= pick;
                cnt   <= '0;
            end
        end else if (!cur.valid) begin
            state <= IDLE;
        end else if (i_resp.ready || tmo) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
        end else begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_aplic_cfg_arbiter.sv
// tb_aplic_cfg_arbiter: directed checks of arbitration order, pass-through,
// timeout, protocol drop and asynchronous reset.
module tb_aplic_cfg_arbiter;
    import aplic_cfg_arbiter_pkg::*;

    logic     i_clk = 1'b0;
    logic     ni_rst = 1'b0;
    cfg_req_t req [2];
    cfg_rsp_t resp [2];
    cfg_req_t oreq;
    cfg_rsp_t iresp;
    logic     busy, tmo;
    int       total = 0;
    int       bad = 0;

    always #5 i_clk = ~i_clk;

    aplic_cfg_arbiter #(.NR_MASTERS(2), .TIMEOUT(8)) dut (
        .i_clk     (i_clk),
        .ni_rst    (ni_rst),
        .i_req     (req),
        .o_resp    (resp),
        .o_req     (oreq),
        .i_resp    (iresp),
        .o_busy    (busy),
        .o_timeout (tmo)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic cfg_req_t mk(input int m, input logic v);
        cfg_req_t r;
        r.addr  = 32'h100 * (m + 1);
        r.write = 1'b1;
        r.wdata = 32'hA0 + m;
        r.wstrb = 4'hf;
        r.valid = v;
        return r;
    endfunction

    task automatic do_reset;
        ni_rst = 1'b0;
        req[0] = mk(0, 1'b0);
        req[1] = mk(1, 1'b0);
        iresp  = '0;
        tick;
        tick;
        ni_rst = 1'b1;
    endtask

    initial begin
        cfg_rsp_t rsp_tmo, rsp_beef;
        rsp_tmo  = '{rdata: 32'h0, error: 1'b1, ready: 1'b1};
        rsp_beef = '{rdata: 32'hDEADBEEF, error: 1'b0, ready: 1'b1};
        req[0] = mk(0, 1'b0);
        req[1] = mk(1, 1'b0);
        iresp  = '0;
        #2;
        chk("rst_req", oreq, 0);
        chk("rst_rsp0", resp[0], 0);
        chk("rst_rsp1", resp[1], 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", tmo, 0);
        do_reset;

        // single write from master 0, slave ready on third busy cycle
        req[0] = '{addr: 32'h4, write: 1'b1, wdata: 32'h1, wstrb: 4'hf, valid: 1'b1};
        #1 chk("t1_idle", oreq.valid, 0);
        tick; #1;
        chk("t1_req", oreq, req[0]);
        chk("t1_busy", busy, 1);
        tick; #1 chk("t1_wait", resp[0].ready, 0);
        tick;
        iresp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        #1;
        chk("t1_rsp0", resp[0], iresp);
        chk("t1_rsp1", resp[1], 0);
        tick;
        req[0].valid = 1'b0;
        iresp = '0;
        #1 chk("t1_idle_after", busy, 0);

        // both masters continuously requesting: 0,1,0,1 with a bubble each
        do_reset;
        req[0] = mk(0, 1'b1);
        req[1] = mk(1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick; #1;
            chk("t2_busy", busy, 1);
            chk("t2_gnt", oreq.addr, 32'h100 * (k % 2 + 1));
            tick;
            iresp = '{rdata: 32'(k), error: 1'b0, ready: 1'b1};
            #1;
            chk("t2_rsp_own", resp[k % 2], iresp);
            chk("t2_rsp_other", resp[1 - k % 2], 0);
            tick;
            iresp = '0;
            #1;
            chk("t2_bubble", busy, 0);
            chk("t2_bubble_valid", oreq.valid, 0);
        end

        // slave never answers: forced error on the 8th busy cycle
        do_reset;
        req[0] = mk(0, 1'b1);
        req[1] = mk(1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick; #1;
            chk("t3_tmo", tmo, logic'(k == 8));
            if (k == 8) begin
                chk("t3_rsp", resp[0], rsp_tmo);
                chk("t3_req_valid", oreq.valid, 0);
            end
        end
        tick;
        req[0].valid = 1'b0;
        #1 chk("t3_idle", busy, 0);

        // master 1 next; ready lands exactly on the timeout cycle
        tick; #1 chk("t4_gnt1", oreq.addr, 32'h200);
        for (int k = 2; k <= 7; k++) begin
            tick; #1 chk("t4_no_tmo", tmo, 0);
        end
        tick;
        iresp = rsp_beef;
        #1;
        chk("t4_rsp", resp[1], rsp_beef);
        chk("t4_tmo", tmo, 0);
        chk("t4_req_valid", oreq.valid, 1);
        tick;
        req[1].valid = 1'b0;
        iresp = '0;

        // master 1 drops valid mid-transaction; pointer must not advance
        do_reset;
        req[0] = mk(0, 1'b1);
        tick;
        tick;
        iresp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        tick;
        iresp = '0;
        req[1] = mk(1, 1'b1);
        tick; #1 chk("t5_gnt1", oreq.addr, 32'h200);
        tick;
        req[1].valid = 1'b0;
        #1;
        chk("t5_drop_valid", oreq.valid, 0);
        chk("t5_drop_busy", busy, 1);
        tick;
        req[1].valid = 1'b1;
        #1 chk("t5_idle", busy, 0);
        tick; #1 chk("t5_rr_kept", oreq.addr, 32'h200);

        // asynchronous reset in the middle of that transaction
        iresp = '{rdata: 32'h1234, error: 1'b0, ready: 1'b0};
        #1 ni_rst = 1'b0;
        #1;
        chk("t6_req", oreq, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rsp1", resp[1], 0);
        tick;
        ni_rst = 1'b1;
        iresp = '0;
        tick; #1 chk("t6_gnt0", oreq.addr, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
